// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared types and constants for the UART receive-FIFO read controller.
//   - state_t  : controller FSM states (2 bits)
//   - owner_t  : which requester currently owns the transfer
//   - width_t  : transfer width, single byte or NBYTES-byte word
//   - lane_pos : maps byte arrival order to its lane in the assembled word
// Configuration macro:
//   UART_RX_BIG_ENDIAN_EN  defined   -> first byte lands in the most significant lane
//                          undefined -> first byte lands in the least significant lane
package uart_rx_pkg;

  localparam int DWIDTH = 8;
  localparam int NBYTES = 4;
  localparam int WWIDTH = DWIDTH * NBYTES;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam int IDX_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BOOT = 2'd1,
    OWN_CORE = 2'd2
  } owner_t;

  typedef enum logic {
    W_BYTE = 1'b0,
    W_WORD = 1'b1
  } width_t;

  // Lane index (0 = bits [7:0]) that receives the idx-th byte of a word.
  function automatic int lane_pos(input int idx);
`ifdef UART_RX_BIG_ENDIAN_EN
    return NBYTES - 1 - idx;
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/uart_rx_word_asm.sv
// uart_rx_word_asm
//   Collects FIFO bytes into a word. Holds the partial lanes and the byte
//   count, and registers the finished (byte zero-extended or word) result on
//   the final capture so the output stays stable between transfers.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   clr        : start of a new transfer, clears count and partial lanes
//   cap        : capture data_byte into the current lane, advance count
//   data_byte  : byte from the FIFO
//   is_word    : 1 = NBYTES-byte word transfer, 0 = single byte
//   word       : registered result, updated only on the final capture
//   last       : the next capture completes the transfer
// Lane order depends on UART_RX_BIG_ENDIAN_EN (see uart_rx_pkg::lane_pos).
module uart_rx_word_asm
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              cap,
  input  logic [DWIDTH-1:0] data_byte,
  input  logic              is_word,
  output logic [WWIDTH-1:0] word,
  output logic              last
);

  logic [DWIDTH-1:0] lane_q [NBYTES];
  logic [CNT_W-1:0]  count_q;
  logic [WWIDTH-1:0] word_q;
  logic [WWIDTH-1:0] assembled;

  assign last = is_word ? (count_q == CNT_W'(NBYTES - 1)) : 1'b1;

  // The byte being captured bypasses its lane register so the result can be
  // registered in the same cycle as the final capture.
  always_comb begin
    assembled = '0;
    if (is_word) begin
      for (int i = 0; i < NBYTES; i++) begin
        assembled[lane_pos(i)*DWIDTH +: DWIDTH] =
          (count_q == CNT_W'(i)) ? data_byte : lane_q[i];
      end
    end else begin
      assembled[DWIDTH-1:0] = data_byte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      word_q  <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        lane_q[i] <= '0;
      end
    end else if (clr) begin
      count_q <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        lane_q[i] <= '0;
      end
    end else if (cap) begin
      lane_q[count_q[IDX_W-1:0]] <= data_byte;
      count_q                    <= count_q + CNT_W'(1);
      if (last) begin
        word_q <= assembled;
      end
    end
  end

  assign word = word_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Sequences reads from the UART receive byte FIFO and shares it between the
//   boot loader and the core. Each request is served as a zero-extended byte
//   or a 32-bit word built from NBYTES FIFO bytes. Fixed priority boot > core;
//   a granted transfer always runs to completion.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   buf_next             : one-cycle pulse requesting the next FIFO byte
//   buf_dout, buf_ready  : FIFO data and its one-cycle valid pulse
//   boot_req, boot_word  : boot request (held until ack), width (1 = word)
//   boot_ack             : boot completion pulse
//   core_req, core_word  : core request (held until ack), width (1 = word)
//   core_ack             : core completion pulse
//   rd_data              : result, valid with ack, held until the next ack
//   busy                 : high whenever the controller is not idle
// Configuration macro:
//   UART_RX_BIG_ENDIAN_EN selects big-endian word assembly (default little).
module uart_rx_ctrl
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  output logic              buf_next,
  input  logic [DWIDTH-1:0] buf_dout,
  input  logic              buf_ready,
  input  logic              boot_req,
  input  logic              boot_word,
  output logic              boot_ack,
  input  logic              core_req,
  input  logic              core_word,
  output logic              core_ack,
  output logic [WWIDTH-1:0] rd_data,
  output logic              busy
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  width_t width_q, width_d;
  logic   clr;
  logic   cap;
  logic   last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      width_q <= W_BYTE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      width_q <= width_d;
    end
  end

  // Requests are only looked at in IDLE, so owner and width are frozen for
  // the whole transfer. buf_next comes only from ISSUE and capture only from
  // WAIT, which keeps next and ready from ever overlapping.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    width_d  = width_q;
    clr      = 1'b0;
    cap      = 1'b0;
    buf_next = 1'b0;
    boot_ack = 1'b0;
    core_ack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (boot_req) begin
          owner_d = OWN_BOOT;
          width_d = boot_word ? W_WORD : W_BYTE;
          clr     = 1'b1;
          state_d = S_ISSUE;
        end else if (core_req) begin
          owner_d = OWN_CORE;
          width_d = core_word ? W_WORD : W_BYTE;
          clr     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        buf_next = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (buf_ready) begin
          cap     = 1'b1;
          state_d = last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        boot_ack = (owner_q == OWN_BOOT);
        core_ack = (owner_q == OWN_CORE);
        owner_d  = OWN_NONE;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

  uart_rx_word_asm u_asm (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .cap       (cap),
    .data_byte (buf_dout),
    .is_word   (width_q == W_WORD),
    .word      (rd_data),
    .last      (last)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Self-checking bench for uart_rx_ctrl. A queue-based FIFO model answers
//   buf_next one cycle later when it holds data. Expected results come from
//   constants and from a byte-queue reference model that assembles words by
//   arithmetic in arrival order.
// Honours UART_RX_BIG_ENDIAN_EN for the expected word layout.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        buf_next;
  logic [7:0]  buf_dout = 8'h00;
  logic        buf_ready = 1'b0;
  logic        boot_req = 1'b0;
  logic        boot_word = 1'b0;
  logic        boot_ack;
  logic        core_req = 1'b0;
  logic        core_word = 1'b0;
  logic        core_ack;
  logic [31:0] rd_data;
  logic        busy;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int exclViol = 0;

  logic [7:0]  fifoQ[$];
  logic [7:0]  dripQ[$];
  logic [7:0]  modelQ[$];
  bit          pend = 1'b0;
  bit          injectReady = 1'b0;

  int          ackOwnQ[$];
  logic [31:0] ackDataQ[$];
  int          ackCycQ[$];
  int          nextCycQ[$];

`ifdef UART_RX_BIG_ENDIAN_EN
  localparam logic [31:0] T1_EXP = 32'h11223344;
  localparam logic [31:0] T5_EXP = 32'h01020304;
  localparam logic [31:0] T6_EXP = 32'hC1C2C3C4;
`else
  localparam logic [31:0] T1_EXP = 32'h44332211;
  localparam logic [31:0] T5_EXP = 32'h04030201;
  localparam logic [31:0] T6_EXP = 32'hC4C3C2C1;
`endif

  uart_rx_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .buf_next  (buf_next),
    .buf_dout  (buf_dout),
    .buf_ready (buf_ready),
    .boot_req  (boot_req),
    .boot_word (boot_word),
    .boot_ack  (boot_ack),
    .core_req  (core_req),
    .core_word (core_word),
    .core_ack  (core_ack),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: a next seen in one cycle is answered with ready in a later
  // cycle as soon as data is available.
  always @(negedge clk) begin
    buf_ready = 1'b0;
    if (!rstn) begin
      fifoQ.delete();
      pend = 1'b0;
    end else if (injectReady) begin
      buf_ready = 1'b1;
      buf_dout  = 8'hFF;
    end else begin
      if (pend && fifoQ.size() > 0) begin
        buf_ready = 1'b1;
        buf_dout  = fifoQ.pop_front();
        pend      = 1'b0;
      end
      if (buf_next) pend = 1'b1;
    end
  end

  // Event recorder for acks and next pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (boot_ack) begin
        ackOwnQ.push_back(0);
        ackDataQ.push_back(rd_data);
        ackCycQ.push_back(cyc);
      end
      if (core_ack) begin
        ackOwnQ.push_back(1);
        ackDataQ.push_back(rd_data);
        ackCycQ.push_back(cyc);
      end
      if (buf_next) nextCycQ.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    #1;
    if (rstn && buf_next && buf_ready) exclViol <= exclViol + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: pops the bytes a transfer consumes, in arrival order.
  function automatic logic [31:0] expectWord(input bit isWord);
    logic [31:0] v;
    logic [7:0]  b;
    v = '0;
    if (!isWord) begin
      b = modelQ.pop_front();
      v = {24'h0, b};
    end else begin
      for (int i = 0; i < 4; i++) begin
        b = modelQ.pop_front();
`ifdef UART_RX_BIG_ENDIAN_EN
        v = (v << 8) | {24'h0, b};
`else
        v = v | ({24'h0, b} << (8 * i));
`endif
      end
    end
    return v;
  endfunction

  task automatic applyStimulus(input bit bReq, input bit bWord, input bit cReq, input bit cWord,
                               output int startCyc);
    @(negedge clk);
    #1;
    boot_word = bWord;
    core_word = cWord;
    boot_req  = bReq;
    core_req  = cReq;
    startCyc  = cyc;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int k;
    k = 0;
    while ((boot_req || core_req) && k < budget) begin
      @(negedge clk);
      #1;
      if (boot_ack) boot_req = 1'b0;
      if (core_ack) core_req = 1'b0;
      if (dripQ.size() > 0 && $urandom_range(0, 2) == 0) fifoQ.push_back(dripQ.pop_front());
      k++;
    end
    if (boot_req || core_req) begin
      checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
      boot_req = 1'b0;
      core_req = 1'b0;
    end
  endtask

  task automatic checkAck(input string tag, input int owner, input logic [31:0] expData,
                          output int ackCyc);
    ackCyc = -1;
    if (ackOwnQ.size() == 0) begin
      checkOutput({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, "_owner"}, 32'(ackOwnQ.pop_front()), 32'(owner));
      checkOutput({tag, "_data"}, ackDataQ.pop_front(), expData);
      ackCyc = ackCycQ.pop_front();
    end
  endtask

  initial begin
    int t0;
    int ac;
    int pushCyc;
    int k;

    $display("[TB] start");
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_ctrl", 32'({buf_next, boot_ack, core_ack, busy}), 32'd0);
    checkOutput("reset_rd", rd_data, 32'd0);
    rstn = 1'b1;

    // Word read for the core with a preloaded FIFO.
    nextCycQ.delete();
    fifoQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, t0);
    waitDone(40, "t1");
    checkOutput("t1_nextcount", 32'(nextCycQ.size()), 32'd4);
    for (int i = 0; i < nextCycQ.size() && i < 4; i++)
      checkOutput($sformatf("t1_next%0d", i), 32'(nextCycQ[i] - t0), 32'(2 * i + 1));
    checkAck("t1", 1, T1_EXP, ac);
    checkOutput("t1_ack_cycle", 32'(ac - t0), 32'd9);

    // Simultaneous byte requests: boot is served first.
    fifoQ = '{8'hA5, 8'h5A};
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, t0);
    waitDone(40, "t3");
    checkAck("t3_first", 0, 32'h000000A5, ac);
    checkOutput("t3_first_cycle", 32'(ac - t0), 32'd3);
    checkAck("t3_second", 1, 32'h0000005A, ac);

    // Empty FIFO: a single next, then wait until data is pushed.
    nextCycQ.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, t0);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("t4_busy", 32'(busy), 32'd1);
    checkOutput("t4_nexts", 32'(nextCycQ.size()), 32'd1);
    checkOutput("t4_noack", 32'(ackOwnQ.size()), 32'd0);
    pushCyc = cyc;
    fifoQ.push_back(8'h7E);
    waitDone(20, "t4");
    checkAck("t4", 1, 32'h0000007E, ac);
    checkOutput("t4_ack_after_push", 32'(ac - pushCyc), 32'd2);

    // Reset while waiting for byte 3 of a word.
    nextCycQ.delete();
    fifoQ = '{8'hDE, 8'hAD};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, t0);
    k = 0;
    while (nextCycQ.size() < 3 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t5_reached_byte3", 32'(nextCycQ.size()), 32'd3);
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("t5_ctrl_zero", 32'({buf_next, boot_ack, core_ack, busy}), 32'd0);
    checkOutput("t5_rd_zero", rd_data, 32'd0);
    core_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    checkOutput("t5_noack", 32'(ackOwnQ.size()), 32'd0);
    fifoQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, t0);
    waitDone(40, "t5");
    checkAck("t5_fresh", 1, T5_EXP, ac);
    checkOutput("t5_fresh_cycle", 32'(ac - t0), 32'd9);

    // Stray ready while idle must be ignored.
    @(negedge clk);
    #1;
    injectReady = 1'b1;
    @(negedge clk);
    #1;
    injectReady = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_rd_held", rd_data, T5_EXP);
    checkOutput("t6_noack", 32'(ackOwnQ.size()), 32'd0);
    checkOutput("t6_idle", 32'(busy), 32'd0);
    fifoQ = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, t0);
    waitDone(40, "t6");
    checkAck("t6_word", 0, T6_EXP, ac);

    // Randomized traffic against the byte-queue model.
    for (int it = 0; it < 25; it++) begin
      int  mode;
      int  n;
      bit  bR, cR, bW, cW, pre;
      logic [7:0] b;
      logic [31:0] e;
      mode = $urandom_range(0, 2);
      bR   = (mode != 1);
      cR   = (mode != 0);
      bW   = 1'($urandom_range(0, 1));
      cW   = 1'($urandom_range(0, 1));
      pre  = 1'($urandom_range(0, 1));
      n    = (bR ? (bW ? 4 : 1) : 0) + (cR ? (cW ? 4 : 1) : 0);
      modelQ.delete();
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        modelQ.push_back(b);
        if (pre) fifoQ.push_back(b);
        else dripQ.push_back(b);
      end
      applyStimulus(bR, bW, cR, cW, t0);
      waitDone(200, $sformatf("rnd%0d", it));
      if (bR) begin
        e = expectWord(bW);
        checkAck($sformatf("rnd%0d_boot", it), 0, e, ac);
        if (pre && !cR) checkOutput($sformatf("rnd%0d_boot_lat", it), 32'(ac - t0), bW ? 32'd9 : 32'd3);
      end
      if (cR) begin
        e = expectWord(cW);
        checkAck($sformatf("rnd%0d_core", it), 1, e, ac);
        if (pre && !bR) checkOutput($sformatf("rnd%0d_core_lat", it), 32'(ac - t0), cW ? 32'd9 : 32'd3);
      end
      fifoQ.delete();
      dripQ.delete();
    end

    checkOutput("next_ready_excl", 32'(exclViol), 32'd0);
    checkOutput("no_extra_acks", 32'(ackOwnQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
